teclado_scan: RTL and testbench

TECLADO_SCAN -- requirements
Module: teclado_scan

---
 rtl/teclado_scan.sv | 190 +++++++++++++++++++
 tb/tb_teclado_scan.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_scan.sv
// Matrix keypad scanner: drives one column low at a time, debounces the sensed rows,
// and hands out one key code per press through a valid/ready holding register.
module teclado_scan #(
    parameter int N_COLS = 4,
    parameter int N_ROWS = 4,
    parameter int DIV    = 27000,
    parameter int DEB    = 4
) (
    input  logic                                clk,
    input  logic                                n_reset,
    input  logic [N_ROWS-1:0]                   filas,
    output logic [N_COLS-1:0]                   columnas,
    output logic [$clog2(N_COLS*N_ROWS)-1:0]    key_code,
    output logic                                key_valid,
    input  logic                                key_ready,
    output logic                                overflow,
    output logic                                scan_tick
);

    localparam int CW  = $clog2(N_COLS*N_ROWS);
    localparam int CLW = $clog2(N_COLS);
    localparam int RW  = $clog2(N_ROWS);
    localparam int DVW = $clog2(DIV);
    localparam int DBW = $clog2(DEB+1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    logic [N_ROWS-1:0] r_sync1;
    logic [N_ROWS-1:0] r_fs;
    logic [DVW-1:0]    r_div;
    state_t            r_state;
    logic [CLW-1:0]    r_col;
    logic [N_COLS-1:0] r_columnas;
    logic [DBW-1:0]    r_deb;
    logic [N_ROWS-1:0] r_pat;
    logic [CW-1:0]     r_key_code;
    logic              r_key_valid;
    logic              r_overflow;

    logic              w_tick;
    logic              w_all_high;
    logic [CLW-1:0]    w_col_adv;
    state_t            w_next_state;
    logic [CLW-1:0]    w_next_col;
    logic [DBW-1:0]    w_next_deb;
    logic [N_ROWS-1:0] w_next_pat;
    logic              w_accept;
    logic [N_ROWS-1:0] w_acc_pat;
    logic [RW-1:0]     w_row;
    logic [CW-1:0]     w_code;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= '1;
            r_fs    <= '1;
        end else begin
            r_sync1 <= filas;
            r_fs    <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DVW'(1);
        end
    end

    assign w_tick     = (r_div == DVW'(DIV-1));
    assign w_all_high = &r_fs;
    assign w_col_adv  = (r_col == CLW'(N_COLS-1)) ? '0 : r_col + CLW'(1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= SCAN;
            r_col      <= '0;
            r_columnas <= ~N_COLS'(1);
            r_deb      <= '0;
            r_pat      <= '1;
        end else begin
            r_state    <= w_next_state;
            r_col      <= w_next_col;
            r_columnas <= ~(N_COLS'(1) << w_next_col);
            r_deb      <= w_next_deb;
            r_pat      <= w_next_pat;
        end
    end

    // The count includes the tick that first saw the pattern, so DEB=1 accepts straight from SCAN.
    always_comb begin
        w_next_state = r_state;
        w_next_col   = r_col;
        w_next_deb   = r_deb;
        w_next_pat   = r_pat;
        w_accept     = 1'b0;
        w_acc_pat    = r_pat;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_all_high) begin
                        w_next_col = w_col_adv;
                    end else begin
                        w_next_pat = r_fs;
                        w_acc_pat  = r_fs;
                        w_next_deb = DBW'(1);
                        if (DEB == 1) begin
                            w_accept     = 1'b1;
                            w_next_state = HELD;
                        end else begin
                            w_next_state = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (r_fs == r_pat) begin
                        if (int'(r_deb) + 1 >= DEB) begin
                            w_accept     = 1'b1;
                            w_next_state = HELD;
                        end else begin
                            w_next_deb = r_deb + DBW'(1);
                        end
                    end else begin
                        w_next_col   = w_col_adv;
                        w_next_state = SCAN;
                        w_next_deb   = '0;
                    end
                end
                HELD: begin
                    if (w_all_high) begin
                        w_next_state = RELEASE;
                        w_next_deb   = DBW'(1);
                    end
                end
                RELEASE: begin
                    if (w_all_high) begin
                        if (int'(r_deb) + 1 >= DEB) begin
                            w_next_col   = w_col_adv;
                            w_next_state = SCAN;
                            w_next_deb   = '0;
                        end else begin
                            w_next_deb = r_deb + DBW'(1);
                        end
                    end else begin
                        w_next_state = HELD;
                    end
                end
                default: w_next_state = SCAN;
            endcase
        end
    end

    // Lowest-numbered closed row wins when several rows are low together.
    always_comb begin
        w_row = '0;
        for (int i = N_ROWS-1; i >= 0; i--) begin
            if (!w_acc_pat[i]) begin
                w_row = RW'(i);
            end
        end
    end

    assign w_code = CW'(int'(w_row) * N_COLS + int'(r_col));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            if (!r_key_valid || key_ready) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (key_ready) begin
            r_key_valid <= 1'b0;
        end
    end

    assign columnas  = r_columnas;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overflow  = r_overflow;
    assign scan_tick = w_tick;

endmodule

// File: tb/tb_teclado_scan.sv
// Directed bench for teclado_scan (4x4, DIV=4, DEB=3) with a behavioural keypad matrix.
module tb_teclado_scan;

    localparam int NC = 4;
    localparam int NR = 4;
    localparam int DV = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overflow;
    logic        scan_tick;
    logic [15:0] keys;

    int vectors     = 0;
    int miscompares = 0;

    teclado_scan #(.N_COLS(NC), .N_ROWS(NR), .DIV(DV), .DEB(DB)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .filas     (filas),
        .columnas  (columnas),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    // Pressed key (row r, col c) pulls row r low only while column c is driven low.
    always_comb begin
        filas = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    task automatic wait_cols(input logic [3:0] pat, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (columnas === pat) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_overflow(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (overflow === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic exp_tick;
        n_reset   = 1'b0;
        keys      = '0;
        key_ready = 1'b0;
        @(negedge clk);
        vectors++; if (columnas !== 4'b1110) begin miscompares++; $display("[TB] FAIL reset_columnas: got %b expected 1110", columnas); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
        vectors++; if (key_code !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++; if (scan_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tick: got %b expected 0", scan_tick); end
        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 1; k <= DV-1; k++) begin
            @(negedge clk);
            exp_tick = (k == DV-1);
            vectors++;
            if (scan_tick !== exp_tick) begin
                miscompares++;
                $display("[TB] FAIL first_tick_cycle%0d: got %b expected %b", k, scan_tick, exp_tick);
            end
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_cols [5];
        int n;
        exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        @(posedge clk); #1;
        vectors++; if (columnas !== exp_cols[0]) begin miscompares++; $display("[TB] FAIL idle_col0: got %b expected %b", columnas, exp_cols[0]); end
        for (int i = 1; i < 5; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (scan_tick !== 1'b1 && n < 20);
            vectors++; if (n != DV) begin miscompares++; $display("[TB] FAIL idle_period%0d: got %0d expected %0d", i, n, DV); end
            @(posedge clk); #1;
            vectors++; if (columnas !== exp_cols[i]) begin miscompares++; $display("[TB] FAIL idle_col%0d: got %b expected %b", i, columnas, exp_cols[i]); end
            vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_valid%0d: got %b expected 0", i, key_valid); end
        end
    endtask

    task automatic test_single_key();
        bit ok;
        int first = -1;
        int vcnt  = 0;
        logic [3:0] code = '0;
        key_ready = 1'b1;
        keys = '0;
        wait_cols(4'b1110, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL key_wait_col0: got timeout expected column 0"); end
        keys[9] = 1'b1;
        wait_cols(4'b1101, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL key_wait_col1: got timeout expected column 1"); end
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                vcnt++;
                if (first < 0) begin first = i; code = key_code; end
            end
        end
        vectors++; if (first != 3*DV) begin miscompares++; $display("[TB] FAIL key_latency: got %0d expected %0d", first, 3*DV); end
        vectors++; if (code !== 4'd9) begin miscompares++; $display("[TB] FAIL key_code: got %0d expected 9", code); end
        vectors++; if (vcnt != 1) begin miscompares++; $display("[TB] FAIL key_single: got %0d expected 1", vcnt); end
        keys = '0;
        wait_cols(4'b1011, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL key_release_resume: got timeout expected column 2"); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL key_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_bounce();
        bit ok;
        bit seen = 1'b0;
        key_ready = 1'b1;
        keys = '0;
        wait_cols(4'b1110, ok);
        keys[1] = 1'b1;
        wait_cols(4'b1101, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL bounce_wait_col1: got timeout expected column 1"); end
        repeat (DV) begin @(negedge clk); if (key_valid) seen = 1'b1; end
        keys = '0;
        repeat (DV) begin @(negedge clk); if (key_valid) seen = 1'b1; end
        vectors++; if (columnas !== 4'b1011) begin miscompares++; $display("[TB] FAIL bounce_next_col: got %b expected 1011", columnas); end
        repeat (20) begin @(negedge clk); if (key_valid) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL bounce_no_key: got %b expected 0", seen); end
    endtask

    task automatic test_overflow();
        bit ok;
        key_ready = 1'b0;
        keys = '0;
        wait_cols(4'b1101, ok);
        keys[14] = 1'b1;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ovf_first_valid: got timeout expected key_valid"); end
        vectors++; if (key_code !== 4'd14) begin miscompares++; $display("[TB] FAIL ovf_first_code: got %0d expected 14", key_code); end
        keys = '0;
        wait_cols(4'b0111, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ovf_release: got timeout expected column 3"); end
        wait_cols(4'b1110, ok);
        keys[1] = 1'b1;
        wait_overflow(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ovf_set: got timeout expected overflow"); end
        vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_valid_kept: got %b expected 1", key_valid); end
        vectors++; if (key_code !== 4'd14) begin miscompares++; $display("[TB] FAIL ovf_code_kept: got %0d expected 14", key_code); end
        keys = '0;
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_consume: got %b expected 0", key_valid); end
        repeat (20) @(negedge clk);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_multirow();
        bit ok;
        key_ready = 1'b1;
        keys = '0;
        wait_cols(4'b1101, ok);
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL multi_valid: got timeout expected key_valid"); end
        vectors++; if (key_code !== 4'd6) begin miscompares++; $display("[TB] FAIL multi_code: got %0d expected 6", key_code); end
        keys = '0;
        wait_cols(4'b0111, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL multi_release: got timeout expected column 3"); end
    endtask

    task automatic test_reset_held();
        bit ok;
        bit seen = 1'b0;
        key_ready = 1'b0;
        keys = '0;
        keys[9] = 1'b1;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL held_valid: got timeout expected key_valid"); end
        vectors++; if (key_code !== 4'd9) begin miscompares++; $display("[TB] FAIL held_code: got %0d expected 9", key_code); end
        repeat (3) @(negedge clk);
        n_reset = 1'b0;
        #1;
        vectors++; if (columnas !== 4'b1110) begin miscompares++; $display("[TB] FAIL hrst_columnas: got %b expected 1110", columnas); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hrst_valid: got %b expected 0", key_valid); end
        vectors++; if (key_code !== 4'd0) begin miscompares++; $display("[TB] FAIL hrst_code: got %0d expected 0", key_code); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL hrst_overflow: got %b expected 0", overflow); end
        vectors++; if (scan_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL hrst_tick: got %b expected 0", scan_tick); end
        keys = '0;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (40) begin @(negedge clk); if (key_valid) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL hrst_no_key: got %b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_bounce();
        test_overflow();
        test_multirow();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
